// File: rtl/scroll_seq_ctrl_pkg.sv
// Shared types and constants for the bouncing-block LED sequencer.
// Package scroll_pkg: FSM state enum, scroll direction, display geometry
// and the two end-of-travel patterns.
package scroll_pkg;

  localparam int LED_W   = 8;
  localparam int BLOCK_W = 3;

  // Block fully at the left (bit7..bit5) and fully at the right (bit2..bit0).
  localparam logic [LED_W-1:0] LEFT_END  = 8'hE0;
  localparam logic [LED_W-1:0] RIGHT_END = 8'h07;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } scroll_state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } scroll_dir_e;

  // Move the block one LED position in the given direction.
  function automatic logic [LED_W-1:0] shift_block(input logic [LED_W-1:0] pattern,
                                                   input scroll_dir_e dir);
    shift_block = (dir == DIR_RIGHT) ? (pattern >> 1) : (pattern << 1);
  endfunction

endpackage

// File: rtl/scroll_seq_ctrl_if.sv
// Control/display bundle between the board switches/buttons, the sequencer
// and the LED bank. The sequencer uses the slave modport; the driver side
// (switch logic or a bench) uses the master modport.
// Optional feature macro: SCROLL_PWM_EN adds the 4-bit duty input.
//
// Handshake semantics: there is no valid/ready pair here. start, stop and
// pause are levels sampled on every rising clk edge (stop wins over all);
// led_out, busy, done, pass_cnt and state_dbg are registered and change
// only on rising clk edges or asynchronously on reset.
interface scroll_seq_ctrl_if;
  import scroll_pkg::*;

  logic                start;
  logic                stop;
  logic                pause;
  logic [1:0]          speed_sel;
`ifdef SCROLL_PWM_EN
  logic [3:0]          duty;
`endif
  logic [LED_W-1:0]    led_out;
  logic                busy;
  logic                done;
  logic [7:0]          pass_cnt;
  scroll_state_e       state_dbg;

`ifdef SCROLL_PWM_EN
  modport master (output start, stop, pause, speed_sel, duty,
                  input  led_out, busy, done, pass_cnt, state_dbg);
  modport slave  (input  start, stop, pause, speed_sel, duty,
                  output led_out, busy, done, pass_cnt, state_dbg);
`else
  modport master (output start, stop, pause, speed_sel,
                  input  led_out, busy, done, pass_cnt, state_dbg);
  modport slave  (input  start, stop, pause, speed_sel,
                  output led_out, busy, done, pass_cnt, state_dbg);
`endif

endinterface

// File: rtl/scroll_seq_ctrl_prescaler.sv
// Step-period counter for the LED sequencer. Counts 0..last while enabled,
// emits a one-cycle tick on the last count and wraps to zero. When enable
// is low the count is frozen; clear forces zero and overrides enable.
module scroll_prescaler #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] last,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && !clr && (cnt_q == last);

  // Next count: clear, wrap on tick, advance when enabled, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scroll_seq_ctrl.sv
// Bouncing 3-LED block sequencer. Runs an IDLE/RUN/PAUSE/DONE FSM, steps the
// block once per prescaler tick, reverses at each end and counts passes.
// Optional feature macro: SCROLL_PWM_EN gates the lit LEDs with a 4-bit
// duty against a free-running counter.
module scroll_seq_ctrl
  import scroll_pkg::*;
#(
  parameter int DIV_BASE = 1_000_000,
  parameter int N_PASSES = 4
) (
  input  logic             clk,
  input  logic             reset,
  scroll_seq_ctrl_if.slave s
);

  // Wide enough for the slowest period, DIV_BASE << 3.
  localparam int              CNT_W      = $clog2(DIV_BASE << 3);
  localparam logic [7:0]      PASS_LIMIT = 8'(N_PASSES);
  localparam bit              LIMITED    = (N_PASSES != 0);

  scroll_state_e     state_q,   state_d;
  scroll_dir_e       dir_q,     dir_d;
  logic [LED_W-1:0]  pattern_q, pattern_d;
  logic [7:0]        pass_cnt_q, pass_cnt_d;
  logic [1:0]        speed_q,   speed_d;
  logic [LED_W-1:0]  led_q,     led_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic [LED_W-1:0]  pwm_mask;

`ifdef SCROLL_PWM_EN
  logic [3:0]        pwm_cnt_q, pwm_cnt_d;
`endif

  logic              active;
  logic              pre_en;
  logic              pre_clr;
  logic              tick;
  logic [CNT_W-1:0]  step_last;
  logic [LED_W-1:0]  next_pattern;

  // Prescaler runs only while a run is live and not held by pause or stop.
  assign active    = (state_q == RUN) || (state_q == PAUSE);
  assign pre_en    = active && !s.pause && !s.stop;
  assign pre_clr   = !active || s.stop;
  assign step_last = CNT_W'((DIV_BASE << speed_q) - 1);

  scroll_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .last  (step_last),
    .tick  (tick)
  );

  assign next_pattern = shift_block(pattern_q, dir_q);

  // FSM next state, block movement, pass counting and registered outputs.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pattern_d  = pattern_q;
    pass_cnt_d = pass_cnt_q;
    speed_d    = speed_q;
`ifdef SCROLL_PWM_EN
    pwm_cnt_d  = pwm_cnt_q + 4'd1;
    pwm_mask   = {LED_W{pwm_cnt_d < s.duty}};
`else
    pwm_mask   = {LED_W{1'b1}};
`endif

    unique case (state_q)
      IDLE: begin
        if (s.start && !s.stop) begin
          state_d    = RUN;
          pattern_d  = LEFT_END;
          dir_d      = DIR_RIGHT;
          pass_cnt_d = 8'd0;
          speed_d    = s.speed_sel;
        end
      end
      RUN, PAUSE: begin
        if (s.stop) begin
          state_d = IDLE;
        end else begin
          state_d = s.pause ? PAUSE : RUN;
          if (tick) begin
            pattern_d = next_pattern;
            speed_d   = s.speed_sel;
            if (((dir_q == DIR_RIGHT) && (next_pattern == RIGHT_END)) ||
                ((dir_q == DIR_LEFT)  && (next_pattern == LEFT_END))) begin
              dir_d      = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
              pass_cnt_d = (pass_cnt_q == 8'hFF) ? 8'hFF : pass_cnt_q + 8'd1;
              if (LIMITED && (pass_cnt_d == PASS_LIMIT)) begin
                state_d = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
    led_d  = (state_d == IDLE) ? '0 : (pattern_d & pwm_mask);
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_RIGHT;
      pattern_q  <= LEFT_END;
      pass_cnt_q <= 8'd0;
      speed_q    <= 2'd0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCROLL_PWM_EN
      pwm_cnt_q  <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pattern_q  <= pattern_d;
      pass_cnt_q <= pass_cnt_d;
      speed_q    <= speed_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SCROLL_PWM_EN
      pwm_cnt_q  <= pwm_cnt_d;
`endif
    end
  end

  assign s.led_out   = led_q;
  assign s.busy      = busy_q;
  assign s.done      = done_q;
  assign s.pass_cnt  = pass_cnt_q;
  assign s.state_dbg = state_q;

endmodule

// File: tb/tb_scroll_seq_ctrl.sv
// Bench for scroll_seq_ctrl with DIV_BASE=4. dut_a stops after 2 passes,
// dut_b runs until stopped. Expected LED values come from the bounce rule:
// after k ticks the block sits at position p = k mod 10 folded into 0..5,
// i.e. 8'hE0 >> p, and k/5 passes are complete.
// Optional feature macro: SCROLL_PWM_EN (duty fixed at 8).
module tb_scroll_seq_ctrl;
  import scroll_pkg::*;

  localparam int DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scroll_seq_ctrl_if ifa ();
  scroll_seq_ctrl_if ifb ();

  scroll_seq_ctrl #(.DIV_BASE(DIV), .N_PASSES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .s     (ifa.slave)
  );

  scroll_seq_ctrl #(.DIV_BASE(DIV), .N_PASSES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .s     (ifb.slave)
  );

  int checks = 0;
  int errors = 0;
  int done_a = 0;
  int done_b = 0;
  logic [7:0] exp_q[$];

  // Reference PWM phase: cycles since reset, modulo 16.
  logic [3:0] pwm_ref;
  always @(posedge clk or posedge reset) begin
    if (reset) pwm_ref <= 4'd0;
    else       pwm_ref <= pwm_ref + 4'd1;
  end

  // Count done pulses on each DUT.
  always @(negedge clk) begin
    if (ifa.done === 1'b1) done_a++;
    if (ifb.done === 1'b1) done_b++;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] bounce(input int k);
    int p;
    logic [7:0] base;
    p = k % 10;
    if (p > 5) p = 10 - p;
    base = 8'hE0;
    return base >> p;
  endfunction

  function automatic logic [7:0] lit_mask();
`ifdef SCROLL_PWM_EN
    return {8{pwm_ref < 4'd8}};
`else
    return 8'hFF;
`endif
  endfunction

  function automatic logic [7:0] led_of(input int d);
    return (d == 0) ? ifa.led_out : ifb.led_out;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? ifa.busy : ifb.busy;
  endfunction

  function automatic logic [7:0] pass_of(input int d);
    return (d == 0) ? ifa.pass_cnt : ifb.pass_cnt;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic st, input logic sp,
                       input logic pa, input logic [1:0] spd);
    if (d == 0) begin
      ifa.start = st; ifa.stop = sp; ifa.pause = pa; ifa.speed_sel = spd;
    end else begin
      ifb.start = st; ifb.stop = sp; ifb.pause = pa; ifb.speed_sel = spd;
    end
  endtask

  // Start a run at speed spd; returns at the negedge of the first RUN cycle.
  task automatic start_run(input int d, input logic [1:0] spd);
    drive(d, 1'b1, 1'b0, 1'b0, spd);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 1'b0, spd);
    chk("start_led", 32'(led_of(d)), 32'(LEFT_END & lit_mask()));
    chk("start_busy", 32'(busy_of(d)), 32'd1);
    chk("start_pass", 32'(pass_of(d)), 32'd0);
  endtask

  // Follow n ticks starting at tick number first_k, each period clocks long.
  task automatic run_ticks(input int d, input int first_k, input int n,
                           input int period, input int npass);
    logic [7:0] prev;
    logic [7:0] nxt;
    logic       eb;
    for (int k = first_k; k < first_k + n; k++) exp_q.push_back(bounce(k));
    prev = bounce(first_k - 1);
    for (int k = first_k; k < first_k + n; k++) begin
      nxt = exp_q.pop_front();
      for (int c = 1; c <= period; c++) begin
        @(negedge clk);
        if (c < period) begin
          chk("hold_led", 32'(led_of(d)), 32'(prev & lit_mask()));
          chk("hold_busy", 32'(busy_of(d)), 32'd1);
        end else begin
          eb = !((npass != 0) && (k / 5 >= npass));
          chk("step_led", 32'(led_of(d)), 32'(nxt & lit_mask()));
          chk("step_pass", 32'(pass_of(d)), 32'(k / 5));
          chk("step_busy", 32'(busy_of(d)), 32'(eb));
        end
      end
      prev = nxt;
    end
  endtask

  // Stop a live run and confirm the return to IDLE without done.
  task automatic stop_run(input int d, input string tag);
    drive(d, 1'b0, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 1'b0, 2'd0);
    chk({tag, "_led"}, 32'(led_of(d)), 32'h0);
    chk({tag, "_busy"}, 32'(busy_of(d)), 32'd0);
    chk({tag, "_done"}, 32'((d == 0) ? ifa.done : ifb.done), 32'd0);
  endtask

  // ---------------- directed / randomized sequence ----------------
  initial begin
    int spd;
    int off;
    int plen;
    int lit;
    logic [7:0] prev;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef SCROLL_PWM_EN
    ifa.duty = 4'd8;
    ifb.duty = 4'd8;
`endif
    #1;
    chk("rst_led", 32'(ifa.led_out), 32'h0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_pass", 32'(ifa.pass_cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_led", 32'(ifa.led_out), 32'h0);

    // 1: two full passes then done.
    start_run(0, 2'd0);
    run_ticks(0, 1, 10, DIV, 2);
    chk("t1_done_pulse", 32'(ifa.done), 32'd1);
    @(negedge clk);
    chk("t1_done_low", 32'(ifa.done), 32'd0);
    chk("t1_led_off", 32'(ifa.led_out), 32'h0);
    chk("t1_busy_off", 32'(ifa.busy), 32'd0);
    chk("t1_done_count", 32'(done_a), 32'd1);

    // 2: random slower speed, steps DIV<<spd apart.
    spd = $urandom_range(1, 3);
    start_run(0, 2'(spd));
    run_ticks(0, 1, 3, DIV << spd, 2);
    stop_run(0, "t2_stop");

    // 3: pause mid-period; the next step slips by exactly the paused cycles.
    for (int rep = 0; rep < 2; rep++) begin
      plen = (rep == 0) ? 7 : $urandom_range(1, 12);
      off  = $urandom_range(1, 2);
      start_run(0, 2'd0);
      run_ticks(0, 1, 1, DIV, 2);
      prev = bounce(1);
      for (int c = 1; c <= DIV + plen; c++) begin
        drive(0, 1'b0, 1'b0, (c > off) && (c <= off + plen), 2'd0);
        @(negedge clk);
        if (c < DIV + plen) begin
          chk("t3_pause_led", 32'(ifa.led_out), 32'(prev & lit_mask()));
          chk("t3_pause_busy", 32'(ifa.busy), 32'd1);
        end else begin
          chk("t3_resume_led", 32'(ifa.led_out), 32'(bounce(2) & lit_mask()));
        end
      end
      run_ticks(0, 3, 1, DIV, 2);
      stop_run(0, "t3_stop");
    end

    // 4: start and stop together in IDLE, then stop mid-run.
    drive(0, 1'b1, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t4_ss_led", 32'(ifa.led_out), 32'h0);
    chk("t4_ss_busy", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    chk("t4_ss_still_idle", 32'(ifa.busy), 32'd0);
    start_run(0, 2'd0);
    run_ticks(0, 1, $urandom_range(1, 7), DIV, 2);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    stop_run(0, "t4_stop");
    @(negedge clk);
    chk("t4_done_count", 32'(done_a), 32'd1);

    // 6: unlimited run, 100 ticks, never done.
    start_run(1, 2'd0);
    run_ticks(1, 1, 100, DIV, 0);
    chk("t6_busy", 32'(ifb.busy), 32'd1);
    chk("t6_pass", 32'(ifb.pass_cnt), 32'd20);
    chk("t6_led", 32'(ifb.led_out), 32'(8'hE0 & lit_mask()));
    chk("t6_no_done", 32'(done_b), 32'd0);
`ifdef SCROLL_PWM_EN
    lit = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (ifb.led_out != 8'h00) lit++;
    end
    chk("t6_pwm_lit", 32'(lit), 32'd8);
`else
    lit = 0;
`endif

    // 5: asynchronous reset mid-run, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("t5_led", 32'(ifb.led_out), 32'h0);
    chk("t5_busy", 32'(ifb.busy), 32'd0);
    chk("t5_pass", 32'(ifb.pass_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_idle_after", 32'(ifb.led_out), 32'h0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
